// File: rtl/tmr_mon_pkg.sv
// rtl/tmr_mon_pkg.sv - shared types and lane codes for tmr_mismatch_monitor
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } tmr_state_e;

  localparam logic [1:0] LANE_A     = 2'd0;
  localparam logic [1:0] LANE_B     = 2'd1;
  localparam logic [1:0] LANE_C     = 2'd2;
  localparam logic [1:0] LANE_MULTI = 2'd3;

  // Lane code of the first mismatched lane; only meaningful for single-lane events.
  function automatic logic [1:0] lane_code(input logic [2:0] mis);
    if (mis[0])      lane_code = LANE_A;
    else if (mis[1]) lane_code = LANE_B;
    else             lane_code = LANE_C;
  endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// rtl/tmr_sat_counter.sv - saturating event counter with synchronous clear
module tmr_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/tmr_mismatch_monitor.sv
// rtl/tmr_mismatch_monitor.sv - TMR lane voter with transient/persistent fault tracking
// Per-lane counters are built only when TMR_MON_COUNTERS_EN is defined.
module tmr_mismatch_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             clr,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       err,
  output logic [2:0]       err_sticky,
  output logic             fault,
  output logic [1:0]       fault_lane,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
);

  localparam logic [3:0] PERSIST_N = 4'(PERSIST);

  logic [WIDTH-1:0] w_vote;
  logic [2:0]       w_mis;
  logic             w_any;
  logic             w_multi;
  logic [1:0]       w_lane;

  tmr_state_e       r_state;
  logic [3:0]       r_run;
  logic [1:0]       r_susp;
  logic [WIDTH-1:0] r_voted;
  logic [2:0]       r_err;
  logic [2:0]       r_sticky;
  logic             r_fault;
  logic [1:0]       r_fault_lane;

  assign w_vote   = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
  assign w_mis[0] = |(in_a ^ w_vote);
  assign w_mis[1] = |(in_b ^ w_vote);
  assign w_mis[2] = |(in_c ^ w_vote);
  assign w_any    = |w_mis;
  assign w_multi  = (w_mis[0] & w_mis[1]) | (w_mis[0] & w_mis[2]) | (w_mis[1] & w_mis[2]);
  assign w_lane   = lane_code(w_mis);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_OK;
      r_run        <= '0;
      r_susp       <= LANE_A;
      r_voted      <= '0;
      r_err        <= '0;
      r_sticky     <= '0;
      r_fault      <= 1'b0;
      r_fault_lane <= LANE_A;
    end else begin
      r_voted <= w_vote;
      r_err   <= w_mis;
      if (clr) begin
        // Clear wins over any event sampled in the same cycle.
        r_state      <= ST_OK;
        r_run        <= '0;
        r_susp       <= LANE_A;
        r_sticky     <= '0;
        r_fault      <= 1'b0;
        r_fault_lane <= LANE_A;
      end else begin
        r_sticky <= r_sticky | w_mis;
        case (r_state)
          ST_OK: begin
            if (w_multi) begin
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_lane <= LANE_MULTI;
            end else if (w_any) begin
              if (PERSIST_N == 4'd1) begin
                r_state      <= ST_FAULT;
                r_fault      <= 1'b1;
                r_fault_lane <= w_lane;
              end else begin
                r_state <= ST_SUSPECT;
                r_susp  <= w_lane;
                r_run   <= 4'd1;
              end
            end
          end
          ST_SUSPECT: begin
            if (w_multi) begin
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_lane <= LANE_MULTI;
            end else if (!w_any) begin
              r_state <= ST_OK;
              r_run   <= '0;
            end else if (w_lane == r_susp) begin
              if (r_run + 4'd1 == PERSIST_N) begin
                r_state      <= ST_FAULT;
                r_fault      <= 1'b1;
                r_fault_lane <= r_susp;
              end
              r_run <= r_run + 4'd1;
            end else begin
              // A different lane restarts the persistence run.
              r_susp <= w_lane;
              r_run  <= 4'd1;
            end
          end
          ST_FAULT: begin
            r_state <= ST_FAULT;
          end
          default: begin
            r_state <= ST_OK;
            r_run   <= '0;
          end
        endcase
      end
    end
  end

  assign voted      = r_voted;
  assign err        = r_err;
  assign err_sticky = r_sticky;
  assign fault      = r_fault;
  assign fault_lane = r_fault_lane;

`ifdef TMR_MON_COUNTERS_EN
  tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .inc(w_mis[0]), .clr(clr), .count(cnt_a)
  );
  tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst(rst), .inc(w_mis[1]), .clr(clr), .count(cnt_b)
  );
  tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk(clk), .rst(rst), .inc(w_mis[2]), .clr(clr), .count(cnt_c)
  );
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
  assign cnt_c = '0;
`endif

endmodule

// File: tb/tb_tmr_mismatch_monitor.sv
// tb/tb_tmr_mismatch_monitor.sv - table-driven bench for tmr_mismatch_monitor
module tb_tmr_mismatch_monitor;

`ifdef TMR_MON_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] a, b, c;
    logic       clr;
    logic [3:0] voted;
    logic [2:0] err, sticky;
    logic       fault;
    logic [1:0] lane;
    logic [7:0] ca, cb, cc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] in_a = '0, in_b = '0, in_c = '0;

  logic [3:0] voted;
  logic [2:0] err, err_sticky;
  logic       fault;
  logic [1:0] fault_lane;
  logic [7:0] cnt_a, cnt_b, cnt_c;

  logic [3:0] s_voted;
  logic [2:0] s_err, s_sticky;
  logic       s_fault;
  logic [1:0] s_lane;
  logic [1:0] s_ca, s_cb, s_cc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tmr_mismatch_monitor #(.WIDTH(4), .PERSIST(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c), .clr(clr),
    .voted(voted), .err(err), .err_sticky(err_sticky), .fault(fault),
    .fault_lane(fault_lane), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c)
  );

  // Saturation instance: narrow counters and a persistence window that never closes here.
  tmr_mismatch_monitor #(.WIDTH(4), .PERSIST(15), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c), .clr(clr),
    .voted(s_voted), .err(s_err), .err_sticky(s_sticky), .fault(s_fault),
    .fault_lane(s_lane), .cnt_a(s_ca), .cnt_b(s_cb), .cnt_c(s_cc)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] ce(input int v);
    ce = CNT_EN ? 8'(v) : 8'd0;
  endfunction

  function automatic vec_t mk(input logic [3:0] a, b, c, input logic cl,
                              input logic [3:0] vo, input logic [2:0] er, st,
                              input logic f, input logic [1:0] ln,
                              input int ca, cb, cc);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.clr = cl;
    v.voted = vo; v.err = er; v.sticky = st; v.fault = f; v.lane = ln;
    v.ca = ce(ca); v.cb = ce(cb); v.cc = ce(cc);
    return v;
  endfunction

  task automatic apply(input logic [3:0] a, b, c, input logic cl);
    in_a = a; in_b = b; in_c = c; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input int idx, input vec_t v);
    chk({nm, ".voted"}, idx, 32'(voted), 32'(v.voted));
    chk({nm, ".err"}, idx, 32'(err), 32'(v.err));
    chk({nm, ".sticky"}, idx, 32'(err_sticky), 32'(v.sticky));
    chk({nm, ".fault"}, idx, 32'(fault), 32'(v.fault));
    chk({nm, ".lane"}, idx, 32'(fault_lane), 32'(v.lane));
    chk({nm, ".cnt_a"}, idx, 32'(cnt_a), 32'(v.ca));
    chk({nm, ".cnt_b"}, idx, 32'(cnt_b), 32'(v.cb));
    chk({nm, ".cnt_c"}, idx, 32'(cnt_c), 32'(v.cc));
  endtask

  vec_t tv[19];

  initial begin
    //          a     b     c    clr  voted err     sticky  f   lane ca cb cc
    tv[0]  = mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0);
    tv[1]  = mk(4'hA, 4'h2, 4'hA, 0, 4'hA, 3'b010, 3'b010, 0, 2'd0, 0, 1, 0);
    tv[2]  = mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b010, 0, 2'd0, 0, 1, 0);
    tv[3]  = mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b010, 0, 2'd0, 0, 1, 0);
    tv[4]  = mk(4'hA, 4'hA, 4'h5, 0, 4'hA, 3'b100, 3'b110, 0, 2'd0, 0, 1, 1);
    tv[5]  = mk(4'hA, 4'hA, 4'h5, 0, 4'hA, 3'b100, 3'b110, 0, 2'd0, 0, 1, 2);
    tv[6]  = mk(4'hA, 4'hA, 4'h5, 0, 4'hA, 3'b100, 3'b110, 1, 2'd2, 0, 1, 3);
    tv[7]  = mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b110, 1, 2'd2, 0, 1, 3);
    tv[8]  = mk(4'hA, 4'hA, 4'hA, 1, 4'hA, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0);
    tv[9]  = mk(4'hA, 4'h2, 4'hA, 0, 4'hA, 3'b010, 3'b010, 0, 2'd0, 0, 1, 0);
    tv[10] = mk(4'hA, 4'h2, 4'hA, 0, 4'hA, 3'b010, 3'b010, 0, 2'd0, 0, 2, 0);
    tv[11] = mk(4'hA, 4'hA, 4'h5, 0, 4'hA, 3'b100, 3'b110, 0, 2'd0, 0, 2, 1);
    tv[12] = mk(4'hA, 4'hA, 4'h5, 0, 4'hA, 3'b100, 3'b110, 0, 2'd0, 0, 2, 2);
    tv[13] = mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b110, 0, 2'd0, 0, 2, 2);
    tv[14] = mk(4'hA, 4'h2, 4'hA, 1, 4'hA, 3'b010, 3'b000, 0, 2'd0, 0, 0, 0);
    tv[15] = mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0);
    tv[16] = mk(4'h1, 4'h2, 4'h0, 0, 4'h0, 3'b011, 3'b011, 1, 2'd3, 1, 1, 0);
    tv[17] = mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b011, 1, 2'd3, 1, 1, 0);
    tv[18] = mk(4'hA, 4'hA, 4'hA, 1, 4'hA, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply(tv[i].a, tv[i].b, tv[i].c, tv[i].clr);
      chk_all("vec", i, tv[i]);
    end

    // Lane A wrong for six cycles: narrow counter saturates, short-window instance faults.
    for (int k = 1; k <= 6; k++) begin
      apply(4'h3, 4'hA, 4'hA, 1'b0);
      chk("sat.cnt_a", k, 32'(s_ca), CNT_EN ? 32'((k > 3) ? 3 : k) : 32'd0);
      chk("sat.fault", k, 32'(s_fault), 32'd0);
      chk("sat.err", k, 32'(s_err), 32'(3'b001));
      chk("main.fault", k, 32'(fault), (k >= 3) ? 32'd1 : 32'd0);
    end
    chk("main.lane", 0, 32'(fault_lane), 32'(2'd0));

    // Asynchronous reset mid-run, sampled before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst.fault", 0, 32'(fault), 32'd0);
    chk("arst.voted", 0, 32'(voted), 32'd0);
    chk("arst.err", 0, 32'(err), 32'd0);
    chk("arst.sticky", 0, 32'(err_sticky), 32'd0);
    chk("arst.cnt_a", 0, 32'(cnt_a), 32'd0);
    chk("arst.sat_cnt_a", 0, 32'(s_ca), 32'd0);
    chk("arst.sat_err", 0, 32'(s_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(4'hA, 4'hA, 4'hA, 1'b0);
    chk_all("post_rst", 0, mk(4'hA, 4'hA, 4'hA, 0, 4'hA, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tmr_mismatch_monitor.md
# tmr_mismatch_monitor

Downstream consumer of a triplicated state machine's three output lanes (A/B/C). Registers the majority-voted value for single-copy logic and compares each lane against the vote. Tracks per-lane disagreement, separates transient upsets from persistent lane faults with a small state machine, and keeps optional per-lane saturating error counters for slow-control readout.

## Interface
Parameters:
- WIDTH, 1, bit width of each lane
- PERSIST, 3, consecutive same-lane mismatch cycles that declare a fault (legal 1..15)
- CNT_W, 8, per-lane error counter width

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- in_a  in  WIDTH  lane A output of upstream TMR block
- in_b  in  WIDTH  lane B
- in_c  in  WIDTH  lane C
- clr  in  1  synchronous clear pulse for flags, FSM and counters
- voted  out  WIDTH  registered bitwise majority of in_a/in_b/in_c
- err  out  3  registered per-lane mismatch this cycle, bit0=A, bit1=B, bit2=C
- err_sticky  out  3  sticky OR of err since last clr/reset
- fault  out  1  persistent fault declared
- fault_lane  out  2  0=A, 1=B, 2=C, 3=MULTI; valid while fault=1
- cnt_a, cnt_b, cnt_c  out  CNT_W  per-lane saturating mismatch counts

## Operation
- Vote: bitwise maj(a,b,c). Lane X mismatched when inX != vote on any bit. multi = two or more lanes mismatched in the same cycle (possible only for WIDTH>1).
- FSM states OK, SUSPECT, FAULT; run counter 4 bits; susp_lane 2 bits.
- OK: no mismatch -> stay. Single-lane mismatch -> SUSPECT, susp_lane=lane, run=1 (if PERSIST=1 -> FAULT directly). multi -> FAULT, fault_lane=3.
- SUSPECT: no mismatch -> OK, run=0. Mismatch on susp_lane -> run+1; when run+1 == PERSIST -> FAULT, fault_lane=susp_lane. Mismatch on a different single lane -> stay SUSPECT, susp_lane=new lane, run=1. multi -> FAULT, fault_lane=3.
- FAULT: held regardless of inputs until clr.
- clr: priority over all events in its cycle; FSM -> OK, run=0, err_sticky=0, counters=0; mismatches sampled that cycle are not counted or stickied. err still reflects that cycle.
- Counters: +1 per cycle the lane mismatches; saturate at 2^CNT_W-1, no wrap.
- Reset values: voted=0, err=0, err_sticky=0, fault=0, fault_lane=0, cnt_*=0, FSM=OK, run=0. Reset mid-SUSPECT or mid-FAULT returns to OK immediately (async).

## Timing
- voted, err: 1 cycle latency from inputs.
- err_sticky, cnt_*: updated on the same edge as err.
- fault rises on the edge that samples the PERSIST-th consecutive same-lane mismatch; with PERSIST=3, mismatch sampled at edges 1,2,3 -> fault=1 after edge 3.
- multi: fault=1 after the sampling edge (1 cycle).
- clr: all flags/counters zero after the clr edge; fault falls on that edge.

## Configuration
- TMR_MON_COUNTERS_EN defined: per-lane saturating counters instantiated as above.
- Undefined: no counter registers; cnt_a/cnt_b/cnt_c driven constant 0; ports remain; FSM, flags and vote unchanged.

## Structure
- Package tmr_mon_pkg: FSM state enum (OK/SUSPECT/FAULT), lane code constants LANE_A=0, LANE_B=1, LANE_C=2, LANE_MULTI=3.
- Sub-module tmr_sat_counter (CNT_W param, inc, clr, count), instantiated three times under TMR_MON_COUNTERS_EN.

## Test plan
- Reset with all lanes 0x0, WIDTH=4 -> all outputs 0; drive all lanes 0xA -> voted=0xA next cycle, err=0, fault=0.
- in_b=0x2 vs 0xA for 1 cycle -> err=3'b010 one cycle, err_sticky=3'b010 held, cnt_b=1, FSM returns OK, fault=0.
- in_c wrong for 3 consecutive cycles, PERSIST=3 -> fault=1, fault_lane=2 after 3rd edge; stays 1 after in_c recovers; clr -> fault=0, cnt_c=0.
- B wrong 2 cycles then C wrong 2 cycles -> no fault (run restarts on lane change); cnt_b=2, cnt_c=2, err_sticky=3'b110.
- in_a=0x1, in_b=0x2, in_c=0x0 (A bit0, B bit1 mismatched) -> fault=1, fault_lane=3 after 1 edge.
- CNT_W=2, A wrong 6 cycles with PERSIST=15 -> cnt_a saturates at 3; reset asserted mid-run -> all outputs 0 immediately.
